// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS control pipeline: control-bundle bit
// positions, stage register layouts, bubble values, forwarding encodings
// and the register-hazard match helper.
package mips_ctrl_pkg;

  localparam int REG_W = 5;
  localparam int WB_W  = 2;
  localparam int M_W   = 3;
  localparam int EX_W  = 5;

  // EX bundle bit positions
  localparam int EX_REGDST   = 0;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUOP_HI = 3;
  localparam int EX_ALUSRC   = 4;

  // M bundle bit positions
  localparam int M_BRANCH   = 0;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 2;

  // WB bundle bit positions (MemtoReg=0 selects memory data)
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  localparam logic [EX_W-1:0] EX_BUBBLE = '0;
  localparam logic [M_W-1:0]  M_BUBBLE  = '0;
  localparam logic [WB_W-1:0] WB_BUBBLE = '0;

  // WB bundle of a load: RegWrite with memory data selected
  localparam logic [WB_W-1:0] WB_LOAD = 2'b01;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic             vld;
    logic [EX_W-1:0]  ex;
    logic [M_W-1:0]   m;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] dst;
  } idex_t;

  typedef struct packed {
    logic             vld;
    logic [M_W-1:0]   m;
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] dst;
  } exmem_t;

  // MEM/WB carries only what WB consumes; a retired bubble has RegWrite=0
  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [REG_W-1:0] dst;
  } memwb_t;

  localparam idex_t  IDEX_BUBBLE  = '0;
  localparam exmem_t EXMEM_BUBBLE = '0;
  localparam memwb_t MEMWB_BUBBLE = '0;

  // A writer hits a reader when it writes a nonzero register the reader
  // names in rs or rt (rt compared even for I-type: conservative).
  function automatic logic reg_hit(input logic rw, input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] rs,
                                   input logic [REG_W-1:0] rt);
    return rw & (dst != '0) & ((dst == rs) | (dst == rt));
  endfunction

  function automatic logic src_match(input logic rw, input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
    return rw & (dst != '0) & (dst == src);
  endfunction

endpackage

// File: rtl/ctrl_pipe_stage_hazard_detect.sv
// Combinational hazard control: stall, IF/ID flush, branch-taken and,
// when CTRL_FWD_EN is defined, the EX operand forwarding selects.
module hazard_detect
  import mips_ctrl_pkg::*;
(
  input  logic             id_valid,
  input  logic             id_j,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_rw,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             mem_rw,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_branch,
  input  logic             mem_zero,
`ifdef CTRL_FWD_EN
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             wb_rw,
  input  logic [REG_W-1:0] wb_dst,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`endif
  output logic             stall,
  output logic             flush_ifid,
  output logic             br_take
);

  logic stall_raw;

  // Stall/flush: a taken branch overrides any stall; a jump flushes only
  // when it actually advances out of ID.
  always_comb begin
    br_take = mem_branch & mem_zero;
`ifdef CTRL_FWD_EN
    stall_raw = id_valid & ex_load & reg_hit(ex_rw, ex_dst, id_rs, id_rt);
`else
    stall_raw = id_valid & (reg_hit(ex_rw, ex_dst, id_rs, id_rt) |
                            reg_hit(mem_rw, mem_dst, id_rs, id_rt));
`endif
    stall      = stall_raw & ~br_take;
    flush_ifid = br_take | (id_valid & id_j & ~stall_raw);
  end

`ifdef CTRL_FWD_EN
  // Forwarding selects from registered state; EX/MEM is the younger result
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (src_match(mem_rw, mem_dst, ex_rs))     fwd_a = FWD_MEM;
    else if (src_match(wb_rw, wb_dst, ex_rs))  fwd_a = FWD_WB;
    if (src_match(mem_rw, mem_dst, ex_rt))     fwd_b = FWD_MEM;
    else if (src_match(wb_rw, wb_dst, ex_rt))  fwd_b = FWD_WB;
  end
`endif

endmodule

// File: rtl/ctrl_pipe_stage.sv
// ID/EX, EX/MEM and MEM/WB control pipeline registers with hazard control.
// Optional feature macro: CTRL_FWD_EN (EX forwarding selects, load-use-only
// stalls). Without it the full RAW stall rule applies.
module ctrl_pipe_stage
  import mips_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_valid,
  input  logic             id_j,
  input  logic [WB_W-1:0]  id_wb,
  input  logic [M_W-1:0]   id_m,
  input  logic [EX_W-1:0]  id_ex,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             mem_zero,
  output logic [EX_W-1:0]  ex_ex,
  output logic [M_W-1:0]   ex_m,
  output logic [WB_W-1:0]  ex_wb,
  output logic [REG_W-1:0] ex_rs,
  output logic [REG_W-1:0] ex_rt,
  output logic [REG_W-1:0] ex_dst,
  output logic [M_W-1:0]   mem_m,
  output logic [WB_W-1:0]  mem_wb,
  output logic [REG_W-1:0] mem_dst,
  output logic [WB_W-1:0]  wb_wb,
  output logic [REG_W-1:0] wb_dst,
`ifdef CTRL_FWD_EN
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
`endif
  output logic             stall,
  output logic             flush_ifid
);

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;
  logic   br_take;

  hazard_detect u_hzd (
    .id_valid   (id_valid),
    .id_j       (id_j),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .ex_rw      (idex_q.vld & idex_q.wb[WB_REGWRITE]),
    .ex_dst     (idex_q.dst),
    .mem_rw     (exmem_q.vld & exmem_q.wb[WB_REGWRITE]),
    .mem_dst    (exmem_q.dst),
    .mem_branch (exmem_q.m[M_BRANCH]),
    .mem_zero   (mem_zero),
`ifdef CTRL_FWD_EN
    .ex_load    (idex_q.vld & (idex_q.wb == WB_LOAD)),
    .ex_rs      (idex_q.rs),
    .ex_rt      (idex_q.rt),
    .wb_rw      (memwb_q.wb[WB_REGWRITE]),
    .wb_dst     (memwb_q.dst),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
`endif
    .stall      (stall),
    .flush_ifid (flush_ifid),
    .br_take    (br_take)
  );

  // Next-state: branch squash > stall bubble > normal advance. Jumps and
  // invalid ID slots enter ID/EX as bubbles so decoder junk never leaks.
  always_comb begin
    idex_d = IDEX_BUBBLE;
    if (!br_take && !stall && id_valid && !id_j) begin
      idex_d.vld = 1'b1;
      idex_d.ex  = id_ex;
      idex_d.m   = id_m;
      idex_d.wb  = id_wb;
      idex_d.rs  = id_rs;
      idex_d.rt  = id_rt;
      idex_d.dst = id_ex[EX_REGDST] ? id_rd : id_rt;
    end
    exmem_d = EXMEM_BUBBLE;
    if (!br_take) begin
      exmem_d.vld = idex_q.vld;
      exmem_d.m   = idex_q.m;
      exmem_d.wb  = idex_q.wb;
      exmem_d.dst = idex_q.dst;
    end
    memwb_d.wb  = exmem_q.wb;
    memwb_d.dst = exmem_q.dst;
  end

  // Stage registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idex_q  <= IDEX_BUBBLE;
      exmem_q <= EXMEM_BUBBLE;
      memwb_q <= MEMWB_BUBBLE;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_ex   = idex_q.ex;
  assign ex_m    = idex_q.m;
  assign ex_wb   = idex_q.wb;
  assign ex_rs   = idex_q.rs;
  assign ex_rt   = idex_q.rt;
  assign ex_dst  = idex_q.dst;
  assign mem_m   = exmem_q.m;
  assign mem_wb  = exmem_q.wb;
  assign mem_dst = exmem_q.dst;
  assign wb_wb   = memwb_q.wb;
  assign wb_dst  = memwb_q.dst;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Directed bench for ctrl_pipe_stage; expectations follow the build
// (CTRL_FWD_EN defined or not).
module tb_ctrl_pipe_stage;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_j, mem_zero;
  logic [1:0] id_wb;
  logic [2:0] id_m;
  logic [4:0] id_ex, id_rs, id_rt, id_rd;
  logic [4:0] ex_ex, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
  logic [2:0] ex_m, mem_m;
  logic [1:0] ex_wb, mem_wb, wb_wb;
  logic       stall, flush_ifid;
`ifdef CTRL_FWD_EN
  logic [1:0] fwd_a, fwd_b;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_pipe_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_j(id_j),
    .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
    .ex_ex(ex_ex), .ex_m(ex_m), .ex_wb(ex_wb),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .mem_m(mem_m), .mem_wb(mem_wb), .mem_dst(mem_dst),
    .wb_wb(wb_wb), .wb_dst(wb_dst),
`ifdef CTRL_FWD_EN
    .fwd_a(fwd_a), .fwd_b(fwd_b),
`endif
    .stall(stall), .flush_ifid(flush_ifid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic j, input logic [1:0] wb,
                        input logic [2:0] m, input logic [4:0] ex,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid = v; id_j = j; id_wb = wb; id_m = m; id_ex = ex;
    id_rs = rs; id_rt = rt; id_rd = rd;
    #1;
  endtask

  // R-type: RegDst=1, ALUOp=010, RegWrite=1, MemtoReg=1 (ALU result)
  task automatic id_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    set_id(1'b1, 1'b0, 2'b11, 3'b000, 5'b00101, rs, rt, rd);
  endtask
  // lw: ALUSrc=1, MemRead, RegWrite with memory data, dst=rt
  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
    set_id(1'b1, 1'b0, 2'b01, 3'b010, 5'b10000, rs, rt, 5'd31);
  endtask
  // beq: ALUOp=001, Branch, no write
  task automatic id_beq(input logic [4:0] rs, input logic [4:0] rt);
    set_id(1'b1, 1'b0, 2'b00, 3'b001, 5'b00010, rs, rt, 5'd0);
  endtask
  task automatic id_bub();
    set_id(1'b0, 1'b0, 2'b00, 3'b000, 5'b00000, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation budget exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    mem_zero = 1'b0;
    id_r(5'd1, 5'd1, 5'd5);            // add $5,$1,$1 waiting under reset
    tick();
    check("rst_ex_ex", ex_ex, 0);
    check("rst_ex_m", ex_m, 0);
    check("rst_ex_wb", ex_wb, 0);
    check("rst_ex_dst", ex_dst, 0);
    check("rst_ex_rs", ex_rs, 0);
    check("rst_ex_rt", ex_rt, 0);
    check("rst_mem_m", mem_m, 0);
    check("rst_mem_wb", mem_wb, 0);
    check("rst_mem_dst", mem_dst, 0);
    check("rst_wb_wb", wb_wb, 0);
    check("rst_wb_dst", wb_dst, 0);
    check("rst_stall", stall, 0);
    check("rst_flush", flush_ifid, 0);
`ifdef CTRL_FWD_EN
    check("rst_fwd_a", fwd_a, 0);
    check("rst_fwd_b", fwd_b, 0);
`endif
    reset_n = 1'b1;
    tick();
    check("cap_ex_ex", ex_ex, 5'b00101);
    check("cap_ex_dst", ex_dst, 5);
    check("cap_ex_wb", ex_wb, 2'b11);

    // RAW: sub $6,$5,$5 directly behind add $5
    id_r(5'd5, 5'd5, 5'd6);
`ifdef CTRL_FWD_EN
    check("raw_stall", stall, 0);
    tick();
    check("raw_ex_dst", ex_dst, 6);
    check("raw_mem_dst", mem_dst, 5);
    check("raw_fwd_a", fwd_a, 2'b10);
    check("raw_fwd_b", fwd_b, 2'b10);
`else
    check("raw_stall1", stall, 1);
    tick();
    check("raw_bub_wb", ex_wb, 0);
    check("raw_mem_dst", mem_dst, 5);
    check("raw_stall2", stall, 1);
    tick();
    check("raw_stall3", stall, 0);
    check("raw_wb_dst", wb_dst, 5);
    check("raw_wb_wb", wb_wb, 2'b11);
    tick();
    check("raw_ex_dst", ex_dst, 6);
    check("raw_ex_rs", ex_rs, 5);
`endif
    id_bub(); tick(); tick(); tick();

    // Load-use: lw $2 then add $3,$2,$4
    id_lw(5'd1, 5'd2);
    tick();
    id_r(5'd2, 5'd4, 5'd3);
    check("lu_stall1", stall, 1);
    check("lu_flush", flush_ifid, 0);
    tick();
    check("lu_bub_wb", ex_wb, 0);
    check("lu_bub_m", ex_m, 0);
`ifdef CTRL_FWD_EN
    check("lu_stall2", stall, 0);
    tick();
    check("lu_ex_dst", ex_dst, 3);
    check("lu_fwd_a", fwd_a, 2'b01);
    check("lu_fwd_b", fwd_b, 2'b00);
`else
    check("lu_stall2", stall, 1);
    tick();
    check("lu_stall3", stall, 0);
    tick();
    check("lu_ex_dst", ex_dst, 3);
`endif
    id_bub(); tick(); tick(); tick();

    // Taken branch reaching MEM while a load-use stall is pending
    id_beq(5'd7, 5'd8);
    tick();
    id_lw(5'd1, 5'd9);
    tick();
    mem_zero = 1'b1;
    id_r(5'd9, 5'd9, 5'd10);
    check("br_mem_m", mem_m, 3'b001);
    check("br_flush", flush_ifid, 1);
    check("br_stall", stall, 0);
    tick();
    mem_zero = 1'b0;
    id_bub();
    check("br_ex_ex", ex_ex, 0);
    check("br_ex_m", ex_m, 0);
    check("br_ex_wb", ex_wb, 0);
    check("br_mem_m0", mem_m, 0);
    check("br_mem_wb", mem_wb, 0);
    check("br_mem_dst", mem_dst, 0);
    check("br_wb_dst", wb_dst, 8);
    check("br_wb_wb", wb_wb, 0);
    check("br_flush0", flush_ifid, 0);

    // Jump with junk decoded fields
    set_id(1'b1, 1'b1, 2'b11, 3'b111, 5'b11111, 5'd20, 5'd21, 5'd22);
    check("j_flush", flush_ifid, 1);
    check("j_stall", stall, 0);
    tick();
    id_bub();
    check("j_ex_ex", ex_ex, 0);
    check("j_ex_m", ex_m, 0);
    check("j_ex_wb", ex_wb, 0);
    check("j_ex_dst", ex_dst, 0);
    check("j_flush0", flush_ifid, 0);

    // Write to $0 followed by a reader of $0
    id_r(5'd1, 5'd2, 5'd0);
    tick();
    id_r(5'd0, 5'd0, 5'd11);
    check("z_stall1", stall, 0);
    tick();
    check("z_mem_wb", mem_wb, 2'b11);
    check("z_mem_dst", mem_dst, 0);
    check("z_stall2", stall, 0);
`ifdef CTRL_FWD_EN
    check("z_fwd_a", fwd_a, 2'b00);
    check("z_fwd_b", fwd_b, 2'b00);
`endif
    id_bub(); tick(); tick(); tick();

    // Reset asserted mid-stall, then normal advance after release
    id_lw(5'd1, 5'd12);
    tick();
    id_r(5'd12, 5'd1, 5'd13);
    check("mr_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    check("mr_ex_wb", ex_wb, 0);
    check("mr_ex_m", ex_m, 0);
    check("mr_stall0", stall, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mr_ex_dst", ex_dst, 13);
    check("mr_ex_wb1", ex_wb, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_stage.md
# ctrl_pipe_stage

Carries the decoded control bundles (J, WB, M, EX) from the decode stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the MIPS core. It also hosts hazard control: load-use and RAW stall generation, squashing on taken branches and jumps, and, optionally, EX-stage operand forwarding selects. It sits between the decode-stage control unit and the datapath muxes of EX, MEM and WB.

## Interface
- No parameters. Register index width is 5, and the bundle widths are fixed: WB=2, M=3, EX=5.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_j` in 1, `id_wb` in 2, `id_m` in 3, `id_ex` in 5: decoded control.
  - Bit positions: EX[0]=RegDst, EX[3:1]=ALUOp, EX[4]=ALUSrc; M[0]=Branch, M[1]=MemRead, M[2]=MemWrite; WB[0]=RegWrite, WB[1]=MemtoReg (0 selects memory data).
- `id_rs`, `id_rt`, `id_rd` in 5: register fields of the ID instruction.
- `mem_zero` in 1: ALU zero flag, registered into EX/MEM by the datapath.
- `ex_ex` out 5, `ex_m` out 3, `ex_wb` out 2: ID/EX control.
- `ex_rs`, `ex_rt`, `ex_dst` out 5: ID/EX register fields and the resolved destination.
- `mem_m` out 3, `mem_wb` out 2, `mem_dst` out 5: EX/MEM control.
- `wb_wb` out 2, `wb_dst` out 5: MEM/WB control.
- `stall` out 1: hold PC and IF/ID.
- `flush_ifid` out 1: replace IF/ID with a bubble at the next edge.
- `fwd_a`, `fwd_b` out 2: EX operand selects. Present only with `CTRL_FWD_EN`.

## Operation
- Resolved destination: `dst = id_ex[0] ? id_rd : id_rt`. It is captured into ID/EX together with the control.
- Bubble: every control bit is 0, `dst` is 0, and the stage's valid bit is 0. A bubble never writes a register or memory and never branches.
- Jumps: a valid `id_j` enters ID/EX as a bubble. The decoder's x fields never propagate.
- Branch taken: `br_take = mem_m[0] & mem_zero` (mem valid implied by nonzero control).
- Hazard match: `hit(stage) = stage RegWrite & stage dst != 0 & (stage dst == id_rs | stage dst == id_rt)`.
  - rt is always compared, even for I-type instructions. This is conservative and accepted.
- Stall:
  - Without forwarding: `stall = id_valid & (hit(ID/EX) | hit(EX/MEM))`. MEM/WB needs no stall because the register file writes before it reads.
  - With forwarding: `stall = id_valid & hit(ID/EX) & ex_wb == 2'b01`, i.e. load-use only.
- Next-state priority at each edge: `br_take` > `stall` > normal advance.
  - `br_take`: ID/EX and EX/MEM load bubbles, `flush_ifid=1`, `stall` is forced to 0. MEM/WB advances normally, so the branch itself retires.
  - `stall`: ID/EX loads a bubble. EX/MEM and MEM/WB advance. The ID instruction is held.
  - Normal advance: all three registers advance. `flush_ifid = id_valid & id_j`.
- Forwarding selects, computed from registered state only:
  - `fwd_a = 2'b10` when EX/MEM RegWrite, `mem_dst != 0` and `mem_dst == ex_rs`.
  - Otherwise `2'b01` when the same test passes for MEM/WB against `ex_rs`.
  - Otherwise `2'b00`.
  - EX/MEM has priority over MEM/WB.
  - `fwd_b` is the same with `ex_rt`.

## Timing
- Asynchronous reset clears all three stage registers: every control output, dst and rs/rt field is 0.
- `stall`, `flush_ifid` and `fwd_*` are combinational. With `id_valid=0` after reset, all of them read 0.
- Latency from ID capture to the EX, MEM and WB outputs is 1, 2 and 3 cycles.
- A load-use hazard costs exactly 1 stall cycle. In the non-forwarding build a RAW hazard costs 2 stall cycles (producer one instruction ahead) or 1 (two ahead).
- A taken branch costs 3 squashed slots (IF/ID, ID/EX, EX/MEM). A jump costs 1.
- Reset asserted mid-stall or mid-flush takes effect immediately. The first post-reset edge with `id_valid=1` advances normally.

## Configuration
- `CTRL_FWD_EN` defined: the forwarding logic and the `fwd_a`/`fwd_b` ports are present, and stalls occur for load-use only.
- `CTRL_FWD_EN` not defined: no forwarding ports, and the full RAW stall rule applies.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - bit-index constants for EX, M and WB (RegDst, ALUOp range, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg);
  - bubble constants;
  - forwarding-select encodings FWD_NONE=00, FWD_WB=01, FWD_MEM=10.
- One sub-module, `hazard_detect`, is natural. It is purely combinational: stall, flush and forwarding selects. The stage registers stay in the top module.

## Test plan
- Reset with `id_valid=1` and an R-type instruction present → all outputs 0 and `stall=0`. After release, `ex_ex=5'b00101` and `ex_dst=id_rd` one cycle later.
- `lw $2`, then `add $3,$2,$4` (forwarding build) → `stall=1` for exactly one cycle and a bubble in EX. Next cycle `fwd_a=2'b01` while the add is in EX.
- `add $5,$1,$1`, then `sub $6,$5,$5` (forwarding build) → no stall, `fwd_a=fwd_b=2'b10`. Same program in the non-forwarding build → `stall=1` for 2 cycles.
- `beq` reaching MEM with `mem_zero=1` while a RAW stall is pending → `flush_ifid=1`, `stall=0`. Next cycle `ex_*` and `mem_*` are all 0, and the beq control appears in `wb_wb`.
- `j` in ID → `flush_ifid=1` for one cycle. `ex_ex`, `ex_m` and `ex_wb` are 0 the next cycle, with no x values.
- Writes to `$0` (dst=0, RegWrite=1), followed by a reader of `$0` → no stall and `fwd_a=2'b00`.
